// File: rtl/trace_scope.sv
`default_nettype none
// ============================================================================
// Module   : trace_scope
// Purpose  : Single-clock logic-analyser style trace capture. After an arm
//            request the block fills a circular sample buffer with PRETRIG
//            pre-trigger samples, waits for a level trigger, records the
//            remaining post-trigger samples and then dumps the whole buffer,
//            oldest sample first, over an 8N1 UART.
// Ports    : clk      - single clock, rising edge
//            rst_n    - asynchronous active-low reset
//            trace_in - WIDTH-bit sample, written every clk while capturing
//            arm      - start-capture request (honoured in IDLE only)
//            trigger  - level trigger (honoured in WAIT only)
//            uart_tx  - 8N1 serial dump, idle high
//            state    - current FSM state code (IDLE=0 .. DUMP=4)
// Options  : SCOPE_HEADER_EN - when defined, each dump starts with the four
//            header bytes 0x53, 0x43, WIDTH/8, DEPTH_LOG2.
// Revision : 1.0 - initial release
// ============================================================================
module trace_scope #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 14,
  parameter int PRETRIG    = 2**(DEPTH_LOG2-1),
  parameter int CLKDIV     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] trace_in,
  input  logic             arm,
  input  logic             trigger,
  output logic             uart_tx,
  output logic [2:0]       state
);

  localparam int DEPTH    = 2**DEPTH_LOG2;
  localparam int NBYTES   = WIDTH / 8;
  localparam int POST_LEN = DEPTH - PRETRIG;
  localparam int BW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DW       = $clog2(CLKDIV);

  localparam logic [DEPTH_LOG2-1:0] PRE_LAST    = (PRETRIG > 0)  ? DEPTH_LOG2'(PRETRIG - 1)  : '0;
  // The trigger sample is written in WAIT, so POST itself writes POST_LEN-1.
  localparam logic [DEPTH_LOG2-1:0] POST_LAST   = (POST_LEN > 1) ? DEPTH_LOG2'(POST_LEN - 2) : '0;
  localparam logic [DEPTH_LOG2-1:0] LAST_SAMPLE = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [DW-1:0]         DIV_LAST    = DW'(CLKDIV - 1);
  localparam logic [BW-1:0]         BYTE_LAST   = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  state_t                fsm;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] cnt;
  logic [DEPTH_LOG2-1:0] sample_cnt;
  logic [BW-1:0]         byte_idx;
  logic [DW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;     // 0 = start, 1..8 = data, 9 = stop
  logic [WIDTH-1:0]      rd_data;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic                  w_we;
  logic                  w_cap_done;
  logic                  w_bit_end;
  logic                  w_sample_end;
  logic                  w_last_byte;
  logic                  w_next_read;
  logic                  w_rd_en;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [WIDTH-1:0]      w_shifted;
  logic [7:0]            w_cur_byte;

`ifdef SCOPE_HEADER_EN
  logic       in_hdr;
  logic [1:0] hdr_cnt;
  logic [7:0] hdr_byte;

  always_comb begin
    hdr_byte = 8'h53;
    case (hdr_cnt)
      2'd0:    hdr_byte = 8'h53;
      2'd1:    hdr_byte = 8'h43;
      2'd2:    hdr_byte = 8'(NBYTES);
      default: hdr_byte = 8'(DEPTH_LOG2);
    endcase
  end

  assign w_cur_byte = in_hdr ? hdr_byte : w_shifted[7:0];
`else
  logic in_hdr;
  assign in_hdr     = 1'b0;
  assign w_cur_byte = w_shifted[7:0];
`endif

  assign state = fsm;

  // PRE writes only when there is at least one pre-trigger sample to keep.
  assign w_we = ((fsm == S_PRE) && (PRETRIG > 0)) || (fsm == S_WAIT) || (fsm == S_POST);

  // Last capture clk: either the final POST sample, or the trigger sample
  // itself when only one post-trigger sample is requested.
  assign w_cap_done = ((fsm == S_POST) && (cnt == POST_LAST)) ||
                      ((fsm == S_WAIT) && trigger && (POST_LEN == 1));

  assign w_bit_end    = (fsm == S_DUMP) && (div_cnt == DIV_LAST);
  assign w_sample_end = !in_hdr && (byte_idx == BYTE_LAST);
  assign w_last_byte  = w_sample_end && (sample_cnt == LAST_SAMPLE);

  // The next sample is fetched as the stop bit of the current sample's last
  // byte begins; the data is not needed again until the next start bit ends,
  // so bytes run back to back despite the 1-clk RAM latency.
  assign w_next_read = w_bit_end && (bit_cnt == 4'd8) && w_sample_end &&
                       (sample_cnt != LAST_SAMPLE);
  assign w_rd_en     = w_cap_done || w_next_read;

  // The oldest sample sits one past the last address written, which is
  // exactly (trigger address - PRETRIG) mod DEPTH.
  assign w_rd_addr = (fsm == S_DUMP) ? rd_ptr : (wr_ptr + DEPTH_LOG2'(1));

  assign w_shifted = rd_data >> {byte_idx, 3'b000};

  // Sample buffer: simple dual-port RAM, never reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[wr_ptr] <= trace_in;
    end
    if (w_rd_en) begin
      rd_data <= mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      uart_tx    <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      sample_cnt <= '0;
      byte_idx   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
`ifdef SCOPE_HEADER_EN
      in_hdr     <= 1'b0;
      hdr_cnt    <= '0;
`endif
    end else begin
      if (w_we) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_next_read) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end

      if (w_cap_done) begin
        // Enter DUMP already driving the first start bit.
        fsm        <= S_DUMP;
        uart_tx    <= 1'b0;
        rd_ptr     <= wr_ptr + DEPTH_LOG2'(2);
        div_cnt    <= '0;
        bit_cnt    <= '0;
        byte_idx   <= '0;
        sample_cnt <= '0;
`ifdef SCOPE_HEADER_EN
        in_hdr     <= 1'b1;
        hdr_cnt    <= '0;
`endif
      end else begin
        case (fsm)
          S_IDLE: begin
            if (arm) begin
              fsm    <= S_PRE;
              wr_ptr <= '0;
              cnt    <= '0;
            end
          end
          S_PRE: begin
            if ((PRETRIG == 0) || (cnt == PRE_LAST)) begin
              fsm <= S_WAIT;
              cnt <= '0;
            end else begin
              cnt <= cnt + DEPTH_LOG2'(1);
            end
          end
          S_WAIT: begin
            if (trigger) begin
              fsm <= S_POST;
              cnt <= '0;
            end
          end
          S_POST: begin
            cnt <= cnt + DEPTH_LOG2'(1);
          end
          S_DUMP: begin
            if (div_cnt != DIV_LAST) begin
              div_cnt <= div_cnt + DW'(1);
            end else begin
              div_cnt <= '0;
              if (bit_cnt == 4'd9) begin
                if (w_last_byte) begin
                  fsm     <= S_IDLE;
                  uart_tx <= 1'b1;
                end else begin
                  bit_cnt <= '0;
                  uart_tx <= 1'b0;
`ifdef SCOPE_HEADER_EN
                  if (in_hdr) begin
                    if (hdr_cnt == 2'd3) begin
                      in_hdr <= 1'b0;
                    end
                    hdr_cnt <= hdr_cnt + 2'd1;
                  end else begin
`else
                  begin
`endif
                    if (byte_idx == BYTE_LAST) begin
                      byte_idx   <= '0;
                      sample_cnt <= sample_cnt + DEPTH_LOG2'(1);
                    end else begin
                      byte_idx <= byte_idx + BW'(1);
                    end
                  end
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                // Moving from data bit 7 into the stop bit drives 1;
                // otherwise the next bit is data bit number bit_cnt.
                uart_tx <= (bit_cnt == 4'd8) ? 1'b1 : w_cur_byte[bit_cnt[2:0]];
              end
            end
          end
          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trace_scope.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_scope
// Purpose  : Self-checking bench for trace_scope (WIDTH=16, DEPTH_LOG2=4,
//            PRETRIG=4, CLKDIV=4). Random trace data is logged per clk edge;
//            the expected dump is taken from that log around the trigger edge
//            and compared against frames decoded from uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_scope;

  localparam int WIDTH      = 16;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int PRETRIG    = 4;
  localparam int CLKDIV     = 4;
  localparam int NB         = WIDTH / 8;
`ifdef SCOPE_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif
  localparam int NBYTES_TOT = HDR + DEPTH * NB;
  localparam int DUMP_CLKS  = NBYTES_TOT * 10 * CLKDIV;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic [WIDTH-1:0] trace_in = '0;
  logic             arm     = 1'b0;
  logic             trigger = 1'b0;
  wire              uart_tx;
  wire  [2:0]       state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;
  logic [WIDTH-1:0] samp [0:16383];

  always #5 clk = ~clk;

  trace_scope #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .PRETRIG    (PRETRIG),
    .CLKDIV     (CLKDIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trace_in (trace_in),
    .arm      (arm),
    .trigger  (trigger),
    .uart_tx  (uart_tx),
    .state    (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  // Advance one clk; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    n_edge++;
    @(negedge clk);
  endtask

  // Present inputs for the next rising edge and log the sample it will see.
  task automatic drive(input logic a, input logic t);
    trace_in = WIDTH'($urandom);
    arm      = a;
    trigger  = t;
    samp[n_edge + 1] = trace_in;
    tick();
  endtask

  task automatic scenario(input bit pre_pulse, input int wait_len, input bit use1234,
                          input int arm_dump_at, input int rst_at);
    int         t;
    int         pos;
    bit         tx_hi;
    logic [9:0] frame;
    logic [WIDTH-1:0] s;
    logic [7:0] exp_b [$];

    drive(1'b1, 1'b0);
    check("arm_to_pre", 32'(state), 32'd1);
    for (int i = 0; i < PRETRIG; i++) begin
      drive(1'b0, pre_pulse && (i == 1));
    end
    check("pre_to_wait", 32'(state), 32'd2);

    tx_hi = 1'b1;
    for (int i = 0; i < wait_len; i++) begin
      drive(1'b0, 1'b0);
      if (uart_tx !== 1'b1) tx_hi = 1'b0;
    end
    if (wait_len > 0) begin
      check("wait_hold", 32'(state), 32'd2);
      check("wait_tx_idle", 32'(tx_hi), 32'd1);
    end

    // Trigger edge.
    trace_in = use1234 ? WIDTH'(16'h1234) : WIDTH'($urandom);
    arm      = 1'b0;
    trigger  = 1'b1;
    t        = n_edge + 1;
    samp[t]  = trace_in;
    tick();
    check("trig_to_post", 32'(state), 32'd3);

    for (int i = 0; i < DEPTH - PRETRIG - 2; i++) begin
      drive(1'b0, 1'($urandom));
    end
    check("post_state", 32'(state), 32'd3);
    check("post_tx_idle", 32'(uart_tx), 32'd1);
    drive(1'b0, 1'($urandom));
    check("dump_entry", 32'(state), 32'd4);

    // Expected byte stream: the DEPTH samples from trigger-PRETRIG onwards.
    exp_b = {};
    if (HDR > 0) begin
      exp_b.push_back(8'h53);
      exp_b.push_back(8'h43);
      exp_b.push_back(8'(NB));
      exp_b.push_back(8'(DEPTH_LOG2));
    end
    for (int k = 0; k < DEPTH; k++) begin
      s = samp[t - PRETRIG + k];
      for (int b = 0; b < NB; b++) begin
        exp_b.push_back(s[8*b +: 8]);
      end
    end
    if (use1234) begin
      check("s1234_lo", 32'(exp_b[HDR + PRETRIG*NB]), 32'h34);
    end

    // Decode frames by sampling each bit mid-way, relative to dump entry.
    pos = 0;
    for (int j = 0; j < NBYTES_TOT; j++) begin
      for (int b = 0; b < 10; b++) begin
        while (pos < (j*10 + b)*CLKDIV + CLKDIV/2) begin
          drive(1'((pos + 1) == arm_dump_at), 1'($urandom));
          pos++;
          if (pos == rst_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_tx", 32'(uart_tx), 32'd1);
            check("rst_state", 32'(state), 32'd0);
            arm = 1'b0;
            trigger = 1'b0;
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            check("rst_idle", 32'(state), 32'd0);
            return;
          end
        end
        frame[b] = uart_tx;
      end
      check($sformatf("byte%0d", j), 32'(frame), 32'({1'b1, exp_b[j], 1'b0}));
    end

    while (pos < DUMP_CLKS - 1) begin
      drive(1'b0, 1'($urandom));
      pos++;
    end
    check("last_stop_state", 32'(state), 32'd4);
    check("last_stop_tx", 32'(uart_tx), 32'd1);
    drive(1'b0, 1'($urandom));
    check("end_state", 32'(state), 32'd0);
    check("end_tx", 32'(uart_tx), 32'd1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'($urandom));
    end
    check("stay_idle", 32'(state), 32'd0);
    check("stay_idle_tx", 32'(uart_tx), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_tx", 32'(uart_tx), 32'd1);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 32'(state), 32'd0);

    scenario(1'b0, 0,  1'b0, -1,  -1);   // trigger at first WAIT clk
    scenario(1'b1, 40, 1'b1, -1,  -1);   // trigger pulse in PRE, wrapped buffer
    scenario(1'b0, 7,  1'b0, 500, -1);   // arm pulse mid-dump
    scenario(1'b0, 3,  1'b0, -1,  173);  // reset mid-byte
    scenario(1'b0, 5,  1'b0, -1,  -1);   // full dump after reset
    for (int r = 0; r < 2; r++) begin
      scenario(1'($urandom), int'($urandom_range(0, 50)), 1'b0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_scope.md
TRACE_SCOPE -- requirements
Module: trace_scope

Interface
REQ-001 SHALL have parameter WIDTH, default 64, sample width in bits; legal values are multiples of 8 from 8 to 128.
REQ-002 SHALL have parameter DEPTH_LOG2, default 14, log2 of the sample buffer depth (DEPTH = 2**DEPTH_LOG2).
REQ-003 SHALL have parameter PRETRIG, default 2**(DEPTH_LOG2-1), number of samples kept before the trigger; legal range is 0 to DEPTH-1.
REQ-004 SHALL have parameter CLKDIV, default 11, clk cycles per UART bit; minimum value is 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port trace_in, input, WIDTH bits: sample sampled every clk while capturing.
REQ-008 SHALL have port arm, input, 1 bit: start-capture request, honoured in IDLE only.
REQ-009 SHALL have port trigger, input, 1 bit: level-sensitive capture trigger.
REQ-010 SHALL have port uart_tx, output, 1 bit: 8N1 serial dump, idle high.
REQ-011 SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-012 SHALL implement FSM states IDLE=0, PRE=1, WAIT=2, POST=3, DUMP=4.
REQ-013 IDLE SHALL move to PRE on the clk where arm=1; the write pointer clears to 0.
REQ-014 In PRE, WAIT and POST, SHALL write trace_in to the buffer at the write pointer every clk, with the pointer wrapping modulo DEPTH.
REQ-015 PRE SHALL last exactly PRETRIG clks, then move to WAIT; trigger is ignored in PRE; when PRETRIG=0, PRE moves to WAIT after one clk without writing.
REQ-016 WAIT SHALL move to POST on the first clk with trigger=1; that clk's sample is the trigger sample and is written.
REQ-017 POST SHALL capture DEPTH-PRETRIG samples in total, counting the trigger sample, then move to DUMP.
REQ-018 DUMP SHALL read DEPTH samples, oldest first, starting at (trigger address - PRETRIG) mod DEPTH.
REQ-019 Each sample SHALL be sent as WIDTH/8 bytes, least-significant byte first.
REQ-020 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); every bit is held for exactly CLKDIV clks.
REQ-021 Consecutive bytes SHALL follow back to back, with no idle gap between them.
REQ-022 The buffer SHALL be a synchronous RAM with 1-clk read latency; the read for the next sample SHALL be issued early enough that no gap appears between bytes.
REQ-023 After the last stop bit SHALL return to IDLE with uart_tx=1.
REQ-024 arm SHALL be ignored in PRE, WAIT, POST and DUMP.
REQ-025 trigger SHALL be ignored outside WAIT.
REQ-026 uart_tx SHALL be 1 in every state except DUMP.
REQ-027 Buffer contents SHALL NOT be cleared by reset or arm; unread locations are undefined.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state=IDLE, uart_tx=1, all pointers and counters to 0.
REQ-029 Reset during any state, including mid-byte in DUMP, SHALL abort the operation; after release the block waits in IDLE for arm.

Configuration
REQ-030 With macro SCOPE_HEADER_EN defined, DUMP SHALL first send 4 header bytes 0x53, 0x43, WIDTH/8, DEPTH_LOG2, then the sample data.
REQ-031 Without SCOPE_HEADER_EN, DUMP SHALL begin directly with the first sample byte; all other behaviour is identical.

Verification (WIDTH=16, DEPTH_LOG2=4, PRETRIG=4, CLKDIV=4, header off unless stated)
REQ-032 Counter input, arm at t0, trigger high at the first WAIT clk -> 16 samples dumped in order trigger-4 .. trigger+11, 32 bytes, 1280 clks.
REQ-033 Trigger pulsed during PRE, then low -> FSM stays in WAIT and uart_tx stays 1 indefinitely.
REQ-034 Trigger asserted 40 clks into WAIT (buffer wrapped) -> dump starts with trigger-4 sample; sample 0x1234 is sent as bytes 0x34 then 0x12.
REQ-035 rst_n asserted mid-byte in DUMP -> same-clk uart_tx=1 and state=0; a new arm and trigger give a correct full dump.
REQ-036 SCOPE_HEADER_EN defined -> first bytes 0x53, 0x43, 0x02, 0x04, then 32 data bytes, 1440 clks.
REQ-037 arm pulsed during DUMP -> ignored; exactly one dump, then IDLE.
